regfile_multiport: RTL and testbench

Parametrised successor to the CPU's 2-read/1-write register file. Adds:
- configurable width, depth and read-port count
- hardwired-zero register 0
- synchronous active-low reset
- end-of-run dump engine that streams every register out, one per cycle, after finish_flag
Sits in the decode stage of the single-cycle RISC-V core. The dump stream feeds the simulation checker.

---
 rtl/regfile_multiport.sv | 104 ++++++++++
 tb/tb_regfile_multiport.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised N-read/1-write register file with end-of-run dump engine
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding while IDLE.
module regfile_multiport #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_READ*ADDR_W-1:0] read_addr,
   output logic [NUM_READ*XLEN-1:0]   read_data,
   input  logic [ADDR_W-1:0]          RD,
   input  logic [XLEN-1:0]            WriteData,
   input  logic                       RegWrite,
   input  logic                       finish_flag,
   output logic                       dump_valid,
   output logic [ADDR_W-1:0]          dump_addr,
   output logic [XLEN-1:0]            dump_data,
   output logic                       dump_done
);
   localparam int NREGS = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

   state_t            state_q;
   logic [XLEN-1:0]   regs_q [NREGS];
   logic              dump_valid_q;
   logic [ADDR_W-1:0] dump_addr_q;
   logic [ADDR_W-1:0] dump_addr_d;
   logic [XLEN-1:0]   dump_data_q;
   logic              dump_done_q;
   logic              wr_en;

   // Writes only land while IDLE so the dumped image is a stable snapshot.
   assign wr_en       = RegWrite && (RD != '0) && (state_q == IDLE);
   assign dump_addr_d = dump_addr_q + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else if (wr_en) begin
         regs_q[RD] <= WriteData;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         dump_done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (finish_flag) begin
                  state_q      <= DUMP;
                  dump_valid_q <= 1'b1;
                  dump_addr_q  <= '0;
                  dump_data_q  <= '0;
               end
            end
            DUMP: begin
               // Counter is exactly ADDR_W wide, so detect the last index explicitly.
               if (dump_addr_q == {ADDR_W{1'b1}}) begin
                  state_q      <= DONE;
                  dump_valid_q <= 1'b0;
                  dump_addr_q  <= '0;
                  dump_data_q  <= '0;
                  dump_done_q  <= 1'b1;
               end else begin
                  dump_addr_q <= dump_addr_d;
                  dump_data_q <= regs_q[dump_addr_d];
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;
   assign dump_done  = dump_done_q;

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = read_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      assign read_data[i*XLEN +: XLEN] = (ra == '0)            ? '0        :
                                         (wr_en && (ra == RD)) ? WriteData :
                                                                 regs_q[ra];
`else
      assign read_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
`endif
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport, default and 64b/16-reg/3-port builds
module tb_regfile_multiport;
   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic [9:0]  read_addr;
   logic [63:0] read_data;
   logic [4:0]  RD;
   logic [31:0] WriteData;
   logic        RegWrite, finish_flag;
   logic        dump_valid, dump_done;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;

   logic [11:0]  c_read_addr;
   logic [191:0] c_read_data;
   logic [3:0]   c_RD;
   logic [63:0]  c_WriteData;
   logic         c_RegWrite, c_finish;
   logic         c_dump_valid, c_dump_done;
   logic [3:0]   c_dump_addr;
   logic [63:0]  c_dump_data;

   regfile_multiport dut (
      .clock(clock), .reset_n(reset_n), .read_addr(read_addr), .read_data(read_data),
      .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite), .finish_flag(finish_flag),
      .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
   );

   regfile_multiport #(.XLEN(64), .ADDR_W(4), .NUM_READ(3)) dut_c (
      .clock(clock), .reset_n(reset_n), .read_addr(c_read_addr), .read_data(c_read_data),
      .RD(c_RD), .WriteData(c_WriteData), .RegWrite(c_RegWrite), .finish_flag(c_finish),
      .dump_valid(c_dump_valid), .dump_addr(c_dump_addr), .dump_data(c_dump_data), .dump_done(c_dump_done)
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  ra0, ra1;
      logic [31:0] e0, e1;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } sb_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model [32];
   logic [63:0] m2 [16];
   sb_t         sb [$];
   vec_t        vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_all();
      sb_t e;
      for (int a = 0; a < 32; a++) begin
         e.a = 5'(a);
         e.d = model[a];
         sb.push_back(e);
      end
   endtask

   // Called on the first dump cycle; pops one scoreboard entry per cycle.
   task automatic drain_dump(input int n);
      sb_t e;
      for (int i = 0; i < n; i++) begin
         chk("dump_valid_hi", {63'd0, dump_valid}, 64'd1);
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
         end else begin
            e = sb.pop_front();
            chk("dump_addr", {59'd0, dump_addr}, {59'd0, e.a});
            chk("dump_data", {32'd0, dump_data}, {32'd0, e.d});
         end
         tick();
      end
      chk("done_valid", {63'd0, dump_valid}, 64'd0);
      chk("done_flag",  {63'd0, dump_done},  64'd1);
      chk("done_addr",  {59'd0, dump_addr},  64'd0);
   endtask

   initial begin
      int          cnt;
      logic [31:0] byp_exp;
      reset_n = 1'b0; read_addr = '0; RD = '0; WriteData = '0; RegWrite = 1'b0; finish_flag = 1'b0;
      c_read_addr = '0; c_RD = '0; c_WriteData = '0; c_RegWrite = 1'b0; c_finish = 1'b0;
      for (int a = 0; a < 32; a++) model[a] = '0;
      for (int a = 0; a < 16; a++) m2[a] = '0;

      tick(); tick();
      chk("rst_valid", {63'd0, dump_valid}, 64'd0);
      chk("rst_done",  {63'd0, dump_done},  64'd0);
      chk("rst_addr",  {59'd0, dump_addr},  64'd0);
      chk("rst_data",  {32'd0, dump_data},  64'd0);
      reset_n = 1'b1;
      tick();

      vecs[0] = '{1'b1, 5'd3,  32'hABCDEFFF, 5'd7,  5'd10, 32'h0,        32'h0};
      vecs[1] = '{1'b1, 5'd5,  32'hFBCDE111, 5'd3,  5'd0,  32'hABCDEFFF, 32'h0};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd3,  5'd5,  32'hABCDEFFF, 32'hFBCDE111};
      vecs[3] = '{1'b0, 5'd7,  32'h55555555, 5'd0,  5'd7,  32'h0,        32'h0};
      vecs[4] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd7,  5'd10, 32'h0,        32'h0};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hDEADBEEF, 32'hFBCDE111};
      for (int v = 0; v < 6; v++) begin
         RegWrite = vecs[v].we; RD = vecs[v].rd; WriteData = vecs[v].wd;
         read_addr = {vecs[v].ra1, vecs[v].ra0};
         #1;
         chk($sformatf("vec%0d_p0", v), {32'd0, read_data[31:0]},  {32'd0, vecs[v].e0});
         chk($sformatf("vec%0d_p1", v), {32'd0, read_data[63:32]}, {32'd0, vecs[v].e1});
         if (vecs[v].we && vecs[v].rd != 5'd0) model[vecs[v].rd] = vecs[v].wd;
         tick();
      end
      RegWrite = 1'b0;

      // Same-cycle forwarding on port 1 only.
      RegWrite = 1'b1; RD = 5'd9; WriteData = 32'h12345678; read_addr = {5'd9, 5'd31};
      #1;
`ifdef REGFILE_BYPASS_EN
      byp_exp = 32'h12345678;
`else
      byp_exp = 32'h0;
`endif
      chk("bypass_p1", {32'd0, read_data[63:32]}, {32'd0, byp_exp});
      chk("bypass_p0", {32'd0, read_data[31:0]},  64'h0000_0000_DEAD_BEEF);
      model[9] = 32'h12345678;
      tick();
      RegWrite = 1'b0;
      #1;
      chk("post_write_9", {32'd0, read_data[63:32]}, 64'h0000_0000_1234_5678);

      // Write committing on the same edge finish_flag is sampled.
      RegWrite = 1'b1; RD = 5'd12; WriteData = 32'hCAFEF00D; finish_flag = 1'b1;
      model[12] = 32'hCAFEF00D;
      push_all();
      tick();
      finish_flag = 1'b0;
      RegWrite = 1'b1; RD = 5'd31; WriteData = 32'h11111111; read_addr = {5'd31, 5'd12};
      #1;
      chk("dump_read_31", {32'd0, read_data[63:32]}, 64'h0000_0000_DEAD_BEEF);
      drain_dump(32);
      RegWrite = 1'b0;
      #1;
      chk("frozen_31", {32'd0, read_data[63:32]}, 64'h0000_0000_DEAD_BEEF);
      chk("commit_12", {32'd0, read_data[31:0]},  64'h0000_0000_CAFE_F00D);
      finish_flag = 1'b1;
      tick(); tick();
      finish_flag = 1'b0;
      chk("done_sticky", {63'd0, dump_done},  64'd1);
      chk("done_noval",  {63'd0, dump_valid}, 64'd0);

      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      read_addr = {5'd5, 5'd3};
      #1;
      chk("rst_clr_3", {32'd0, read_data[31:0]}, 64'd0);
      chk("rst_clr_5", {32'd0, read_data[63:32]}, 64'd0);
      chk("rst2_valid", {63'd0, dump_valid}, 64'd0);
      chk("rst2_done",  {63'd0, dump_done},  64'd0);

      // Abort a dump at index 10.
      RegWrite = 1'b1; RD = 5'd20; WriteData = 32'h0BADF00D;
      tick();
      RegWrite = 1'b0; finish_flag = 1'b1;
      tick();
      finish_flag = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         chk("abort_walk", {59'd0, dump_addr}, 64'(i));
         if (i < 10) tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      read_addr = {5'd20, 5'd20};
      #1;
      chk("abort_valid", {63'd0, dump_valid}, 64'd0);
      chk("abort_done",  {63'd0, dump_done},  64'd0);
      chk("abort_clr20", {32'd0, read_data[31:0]}, 64'd0);
      for (int a = 0; a < 32; a++) model[a] = '0;
      sb.delete();
      finish_flag = 1'b1;
      push_all();
      tick();
      finish_flag = 1'b0;
      drain_dump(32);

      // 64-bit, 16-register, 3-port instance.
      c_RegWrite = 1'b1;
      c_RD = 4'd1;  c_WriteData = 64'h0123456789ABCDEF; m2[1]  = c_WriteData; tick();
      c_RD = 4'd6;  c_WriteData = 64'hFEDCBA9876543210; m2[6]  = c_WriteData; tick();
      c_RD = 4'd15; c_WriteData = 64'hA5A55A5A0F0FF0F0; m2[15] = c_WriteData; tick();
      c_RegWrite = 1'b0;
      c_read_addr = {4'd1, 4'd6, 4'd15};
      #1;
      chk("c_p0", c_read_data[63:0],    64'hA5A55A5A0F0FF0F0);
      chk("c_p1", c_read_data[127:64],  64'hFEDCBA9876543210);
      chk("c_p2", c_read_data[191:128], 64'h0123456789ABCDEF);
      c_finish = 1'b1;
      tick();
      c_finish = 1'b0;
      cnt = 0;
      for (int cyc = 0; cyc < 30 && !c_dump_done; cyc++) begin
         if (c_dump_valid) begin
            chk("c_dump_addr", {60'd0, c_dump_addr}, 64'(cnt));
            chk("c_dump_data", c_dump_data, m2[cnt[3:0]]);
            cnt++;
         end
         tick();
      end
      chk("c_dump_len",  64'(cnt), 64'd16);
      chk("c_dump_done", {63'd0, c_dump_done}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
